// File: rtl/lsu_axi_bridge_pkg.sv
// Shared types for the LSU-to-AXI bridge: LSU bus request/response records,
// AXI burst/size encodings and the bridge state enum.
package lsu_axi_bridge_pkg;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic        burst;
      logic        cached;
      logic [31:0] addr;
      logic [31:0] w_data;
      logic [3:0]  data_strobe;
      logic        data_ok;
      logic        data_last;
   } cache_bus_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] r_data;
      logic        data_ok;
      logic        data_last;
   } cache_bus_resp_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [2:0] AXI_SIZE_1B = 3'b000;
   localparam logic [2:0] AXI_SIZE_2B = 3'b001;
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WADDR = 3'd3,
      ST_WDATA = 3'd4,
      ST_WRESP = 3'd5
   } bridge_state_t;

   // Word-align an address for a single-beat transfer.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_axi_bridge_if.sv
// LSU request/response plus the five AXI4 channels seen by the bridge.
// master = bridge side (AXI master, LSU responder); slave = LSU/memory side.
interface lsu_axi_bridge_if;
   import lsu_axi_bridge_pkg::*;

   cache_bus_req_t  bus_req;
   cache_bus_resp_t bus_resp;

   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        ar_valid;
   logic        ar_ready;

   logic [31:0] r_data;
   logic        r_last;
   logic        r_valid;
   logic        r_ready;

   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        aw_valid;
   logic        aw_ready;

   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        w_valid;
   logic        w_ready;

   logic        b_valid;
   logic        b_ready;

   modport master (
      input  bus_req, ar_ready, r_data, r_last, r_valid, aw_ready, w_ready, b_valid,
      output bus_resp, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
             aw_addr, aw_len, aw_size, aw_burst, aw_valid,
             w_data, w_strb, w_last, w_valid, b_ready
   );

   modport slave (
      output bus_req, ar_ready, r_data, r_last, r_valid, aw_ready, w_ready, b_valid,
      input  bus_resp, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
             aw_addr, aw_len, aw_size, aw_burst, aw_valid,
             w_data, w_strb, w_last, w_valid, b_ready
   );

endinterface

// File: rtl/lsu_axi_bridge.sv
// LSU-to-AXI4 bridge: one outstanding transaction, replayed as AR/R or AW/W/B.
// Writes are acknowledged to the LSU only after B so LSU ordering holds.
// Optional feature macro: LSU_BRIDGE_BURST_EN (multi-beat INCR bursts of BURST_LEN).
module lsu_axi_bridge
   import lsu_axi_bridge_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input logic              clk,
   input logic              rst,
   lsu_axi_bridge_if.master bus
);

   localparam int          CNT_W      = $clog2(BURST_LEN);
   localparam logic [31:0] BURST_MASK = 32'(BURST_LEN * 4 - 1);

   bridge_state_t     state_r, state_nx_s;
   logic [31:0]       addr_r, addr_nx_s;
   logic              burst_r, burst_nx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
   logic              req_burst_s;
   logic              w_last_s;
   logic              unused_fields_s;

`ifdef LSU_BRIDGE_BURST_EN
   assign req_burst_s     = bus.bus_req.burst;
   assign w_last_s        = burst_r ? (cnt_r == CNT_W'(BURST_LEN - 1)) : 1'b1;
   assign unused_fields_s = ^{bus.bus_req.cached, bus.bus_req.data_last};
`else
   assign req_burst_s     = 1'b0;
   assign w_last_s        = 1'b1;
   assign unused_fields_s = ^{bus.bus_req.burst, bus.bus_req.cached, bus.bus_req.data_last};
`endif

   // Address channels are driven from the latched request and stay stable while valid.
   assign bus.ar_addr  = addr_r;
   assign bus.ar_len   = burst_r ? 8'(BURST_LEN - 1) : 8'd0;
   assign bus.ar_size  = AXI_SIZE_4B;
   assign bus.ar_burst = AXI_BURST_INCR;
   assign bus.aw_addr  = addr_r;
   assign bus.aw_len   = burst_r ? 8'(BURST_LEN - 1) : 8'd0;
   assign bus.aw_size  = AXI_SIZE_4B;
   assign bus.aw_burst = AXI_BURST_INCR;

   // State, latched request and beat counter; reset abandons any AXI transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         addr_r  <= 32'd0;
         burst_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         addr_r  <= addr_nx_s;
         burst_r <= burst_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Next-state logic and per-state channel/LSU handshakes.
   always_comb begin
      state_nx_s   = state_r;
      addr_nx_s    = addr_r;
      burst_nx_s   = burst_r;
      cnt_nx_s     = cnt_r;
      bus.bus_resp = '0;
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b0;
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
      bus.w_data   = 32'd0;
      bus.w_strb   = 4'd0;
      bus.w_last   = 1'b0;
      bus.b_ready  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.bus_req.valid) begin
               bus.bus_resp.ready = 1'b1;
               burst_nx_s = req_burst_s;
               addr_nx_s  = req_burst_s ? (bus.bus_req.addr & ~BURST_MASK)
                                        : word_align(bus.bus_req.addr);
               cnt_nx_s   = '0;
               state_nx_s = bus.bus_req.write ? ST_WADDR : ST_RADDR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RADDR: begin
            bus.ar_valid = 1'b1;
            if (bus.ar_ready) begin
               state_nx_s = ST_RDATA;
            end else begin
               state_nx_s = ST_RADDR;
            end
         end
         ST_RDATA: begin
            bus.r_ready            = bus.bus_req.data_ok;
            bus.bus_resp.data_ok   = bus.r_valid & bus.bus_req.data_ok;
            bus.bus_resp.r_data    = bus.r_data;
            bus.bus_resp.data_last = bus.r_last;
            if (bus.r_valid && bus.bus_req.data_ok) begin
               cnt_nx_s   = cnt_r + CNT_W'(1);
               state_nx_s = bus.r_last ? ST_IDLE : ST_RDATA;
            end else begin
               state_nx_s = ST_RDATA;
            end
         end
         ST_WADDR: begin
            bus.aw_valid = 1'b1;
            if (bus.aw_ready) begin
               state_nx_s = ST_WDATA;
            end else begin
               state_nx_s = ST_WADDR;
            end
         end
         ST_WDATA: begin
            bus.w_valid = bus.bus_req.data_ok;
            bus.w_data  = bus.bus_req.w_data;
            bus.w_strb  = bus.bus_req.data_strobe;
            bus.w_last  = w_last_s;
            if (bus.bus_req.data_ok && bus.w_ready) begin
               cnt_nx_s = cnt_r + CNT_W'(1);
               if (w_last_s) begin
                  state_nx_s = ST_WRESP;
               end else begin
                  bus.bus_resp.data_ok = 1'b1;
                  state_nx_s = ST_WDATA;
               end
            end else begin
               state_nx_s = ST_WDATA;
            end
         end
         ST_WRESP: begin
            bus.b_ready = 1'b1;
            if (bus.b_valid) begin
               bus.bus_resp.data_ok   = 1'b1;
               bus.bus_resp.data_last = 1'b1;
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WRESP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Self-checking bench for lsu_axi_bridge: a per-cycle vector table for the
// single-beat read/write/backpressure/reset cases, plus hand-written sequences
// for back-to-back requests and (with LSU_BRIDGE_BURST_EN) bursts.
module tb_lsu_axi_bridge;
   import lsu_axi_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   lsu_axi_bridge_if bus_if();

   lsu_axi_bridge #(.BURST_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // in  bits: {rst,valid,write,data_ok,ar_ready,r_valid,r_last,aw_ready,w_ready,b_valid}
   // exp bits: {ready,resp_ok,resp_last,ar_valid,r_ready,aw_valid,w_valid,w_last,b_ready}
   typedef struct {
      logic [9:0]  i;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [8:0]  e;
      logic [31:0] ea;
      logic [31:0] ed;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [9:0] i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [8:0] e, input logic [31:0] ea,
                      input logic [31:0] ed);
      vec_t v;
      v.i = i; v.a = a; v.d = d; v.s = s; v.e = e; v.ea = ea; v.ed = ed;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus_if.bus_req  = '0;
      bus_if.ar_ready = 1'b0;
      bus_if.r_data   = 32'd0;
      bus_if.r_last   = 1'b0;
      bus_if.r_valid  = 1'b0;
      bus_if.aw_ready = 1'b0;
      bus_if.w_ready  = 1'b0;
      bus_if.b_valid  = 1'b0;
   endtask

   function automatic logic [8:0] flags();
      return {bus_if.bus_resp.ready, bus_if.bus_resp.data_ok, bus_if.bus_resp.data_last,
              bus_if.ar_valid, bus_if.r_ready, bus_if.aw_valid, bus_if.w_valid,
              bus_if.w_last, bus_if.b_ready};
   endfunction

   initial begin
      clear_inputs();
      // reset state
      add(10'b1000000000, 32'h0, 32'h0, 4'h0, 9'b000000000, 32'h0, 32'h0);
      // read word, ar_ready after 2 cycles
      add(10'b0100000000, 32'h1C000006, 32'h0, 4'h0, 9'b100000000, 32'h0, 32'h0);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h1C000004, 32'h0);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h1C000004, 32'h0);
      add(10'b0000100000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h1C000004, 32'h0);
      add(10'b0001000000, 32'h0, 32'h0, 4'h0, 9'b000010000, 32'h0, 32'h0);
      add(10'b0001011000, 32'h0, 32'hDEADBEEF, 4'h0, 9'b011010000, 32'h0, 32'hDEADBEEF);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000000000, 32'h0, 32'h0);
      // read with LSU backpressure for 3 cycles
      add(10'b0100000000, 32'h00000100, 32'h0, 4'h0, 9'b100000000, 32'h0, 32'h0);
      add(10'b0000100000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h00000100, 32'h0);
      for (int k = 0; k < 3; k++)
         add(10'b0000011000, 32'h0, 32'h12345678, 4'h0, 9'b001000000, 32'h0, 32'h12345678);
      add(10'b0001011000, 32'h0, 32'h12345678, 4'h0, 9'b011010000, 32'h0, 32'h12345678);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000000000, 32'h0, 32'h0);
      // byte write, aw_ready delayed 3, b_valid 4 cycles after W
      add(10'b0110000000, 32'h80000003, 32'hAB000000, 4'b1000, 9'b100000000, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++)
         add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000001000, 32'h80000000, 32'h0);
      add(10'b0000000100, 32'h0, 32'h0, 4'h0, 9'b000001000, 32'h80000000, 32'h0);
      add(10'b0000000010, 32'h0, 32'hAB000000, 4'b1000, 9'b000000010, 32'h0, 32'h0);
      add(10'b0001000010, 32'h0, 32'hAB000000, 4'b1000, 9'b000000110, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++)
         add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000000001, 32'h0, 32'h0);
      add(10'b0000000001, 32'h0, 32'h0, 4'h0, 9'b011000001, 32'h0, 32'h0);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000000000, 32'h0, 32'h0);
      // reset in RDATA after a first beat, then a fresh read
      add(10'b0100000000, 32'h00000200, 32'h0, 4'h0, 9'b100000000, 32'h0, 32'h0);
      add(10'b0000100000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h00000200, 32'h0);
      add(10'b0001010000, 32'h0, 32'h11111111, 4'h0, 9'b010010000, 32'h0, 32'h11111111);
      add(10'b1001000000, 32'h0, 32'h0, 4'h0, 9'b000010000, 32'h0, 32'h0);
      add(10'b0001010000, 32'h0, 32'h00000055, 4'h0, 9'b000000000, 32'h0, 32'h0);
      add(10'b0100000000, 32'h00000300, 32'h0, 4'h0, 9'b100000000, 32'h0, 32'h0);
      add(10'b0000100000, 32'h0, 32'h0, 4'h0, 9'b000100000, 32'h00000300, 32'h0);
      add(10'b0001011000, 32'h0, 32'hCAFEF00D, 4'h0, 9'b011010000, 32'h0, 32'hCAFEF00D);
      add(10'b0000000000, 32'h0, 32'h0, 4'h0, 9'b000000000, 32'h0, 32'h0);

      foreach (vq[n]) begin
         @(negedge clk);
         rst                         = vq[n].i[9];
         bus_if.bus_req.valid        = vq[n].i[8];
         bus_if.bus_req.write        = vq[n].i[7];
         bus_if.bus_req.data_ok      = vq[n].i[6];
         bus_if.ar_ready             = vq[n].i[5];
         bus_if.r_valid              = vq[n].i[4];
         bus_if.r_last               = vq[n].i[3];
         bus_if.aw_ready             = vq[n].i[2];
         bus_if.w_ready              = vq[n].i[1];
         bus_if.b_valid              = vq[n].i[0];
         bus_if.bus_req.addr         = vq[n].a;
         bus_if.bus_req.w_data       = vq[n].d;
         bus_if.r_data               = vq[n].d;
         bus_if.bus_req.data_strobe  = vq[n].s;
         #1;
         chk($sformatf("vec%0d flags", n), 64'(flags()), 64'(vq[n].e));
         chk($sformatf("vec%0d resp_rdata", n), 64'(bus_if.bus_resp.r_data), 64'(vq[n].ed));
         if (vq[n].e[5])
            chk($sformatf("vec%0d ar", n),
                64'({bus_if.ar_addr, bus_if.ar_len, bus_if.ar_size, bus_if.ar_burst}),
                64'({vq[n].ea, 8'd0, 3'b010, 2'b01}));
         if (vq[n].e[3])
            chk($sformatf("vec%0d aw", n),
                64'({bus_if.aw_addr, bus_if.aw_len, bus_if.aw_size, bus_if.aw_burst}),
                64'({vq[n].ea, 8'd0, 3'b010, 2'b01}));
         if (vq[n].e[2])
            chk($sformatf("vec%0d w", n), 64'({bus_if.w_data, bus_if.w_strb}),
                64'({vq[n].d, vq[n].s}));
      end

      // back-to-back write then read with valid held continuously
      begin
         int br_cnt = 0;
         int overlap = 0;
         bit first = 1'b0, second = 1'b0, wdone = 1'b0, ar_seen = 1'b0;
         @(negedge clk);
         clear_inputs();
         bus_if.bus_req.valid       = 1'b1;
         bus_if.bus_req.addr        = 32'h00000040;
         bus_if.bus_req.w_data      = 32'h01020304;
         bus_if.bus_req.data_strobe = 4'hF;
         bus_if.bus_req.data_ok     = 1'b1;
         bus_if.ar_ready = 1'b1;
         bus_if.aw_ready = 1'b1;
         bus_if.w_ready  = 1'b1;
         bus_if.r_valid  = 1'b1;
         bus_if.r_last   = 1'b1;
         for (int k = 0; k < 40 && !ar_seen; k++) begin
            if (k > 0) @(negedge clk);
            bus_if.bus_req.write = !first;
            bus_if.b_valid = (br_cnt >= 2);
            #1;
            if (bus_if.ar_valid && bus_if.b_ready) overlap++;
            if (bus_if.b_ready && bus_if.b_valid) wdone = 1'b1;
            if (bus_if.b_ready) br_cnt++;
            if (bus_if.bus_resp.ready) begin
               if (!first) begin
                  first = 1'b1;
               end else if (!second) begin
                  second = 1'b1;
                  chk("b2b second_ready_after_wresp", 64'(wdone), 64'(1));
               end
            end
            if (second && bus_if.ar_valid && !ar_seen) begin
               ar_seen = 1'b1;
               chk("b2b read_ar_addr", 64'(bus_if.ar_addr), 64'h40);
            end
         end
         chk("b2b second_ready_seen", 64'(second), 64'(1));
         chk("b2b read_issued", 64'(ar_seen), 64'(1));
         chk("b2b ar_b_overlap", 64'(overlap), 64'(0));
         @(negedge clk);
         bus_if.bus_req.valid = 1'b0;
         repeat (3) @(negedge clk);
         clear_inputs();
         #1;
         chk("b2b back_to_idle", 64'(flags()), 64'(0));
      end

`ifdef LSU_BRIDGE_BURST_EN
      // read burst of 4
      @(negedge clk);
      bus_if.bus_req.valid = 1'b1;
      bus_if.bus_req.burst = 1'b1;
      bus_if.bus_req.addr  = 32'h00001234;
      #1 chk("burst_rd accept", 64'(bus_if.bus_resp.ready), 64'(1));
      @(negedge clk);
      bus_if.bus_req.valid = 1'b0;
      bus_if.ar_ready = 1'b1;
      #1 chk("burst_rd ar", 64'({bus_if.ar_valid, bus_if.ar_addr, bus_if.ar_len}),
              64'({1'b1, 32'h00001230, 8'd3}));
      for (int b = 1; b <= 4; b++) begin
         @(negedge clk);
         bus_if.ar_ready = 1'b0;
         bus_if.bus_req.data_ok = 1'b1;
         bus_if.r_valid = 1'b1;
         bus_if.r_last  = (b == 4);
         bus_if.r_data  = 32'(b);
         #1 chk($sformatf("burst_rd beat%0d", b),
                64'({bus_if.bus_resp.data_ok, bus_if.bus_resp.data_last, bus_if.bus_resp.r_data}),
                64'({1'b1, (b == 4), 32'(b)}));
      end
      @(negedge clk);
      clear_inputs();
      // write burst of 4
      bus_if.bus_req.valid = 1'b1;
      bus_if.bus_req.write = 1'b1;
      bus_if.bus_req.burst = 1'b1;
      bus_if.bus_req.addr  = 32'h00002008;
      #1 chk("burst_wr accept", 64'(bus_if.bus_resp.ready), 64'(1));
      @(negedge clk);
      bus_if.bus_req.valid = 1'b0;
      bus_if.aw_ready = 1'b1;
      #1 chk("burst_wr aw", 64'({bus_if.aw_valid, bus_if.aw_addr, bus_if.aw_len}),
              64'({1'b1, 32'h00002000, 8'd3}));
      for (int b = 1; b <= 4; b++) begin
         @(negedge clk);
         bus_if.aw_ready = 1'b0;
         bus_if.bus_req.data_ok = 1'b1;
         bus_if.bus_req.data_last = 1'b0;
         bus_if.w_ready = 1'b1;
         #1 chk($sformatf("burst_wr beat%0d", b),
                64'({bus_if.w_valid, bus_if.w_last, bus_if.bus_resp.data_ok}),
                64'({1'b1, (b == 4), (b != 4)}));
      end
      @(negedge clk);
      clear_inputs();
      bus_if.b_valid = 1'b1;
      #1 chk("burst_wr bresp", 64'({bus_if.b_ready, bus_if.bus_resp.data_ok, bus_if.bus_resp.data_last}),
              64'(3'b111));
      @(negedge clk);
      clear_inputs();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
